// File: rtl/lsu_multicycle.sv
// Multi-cycle load/store unit: handshaked memory access, big-endian lanes, RA update writeback.
// Define LSU_ALIGN_CHECK_EN to fault misaligned half/word accesses instead of force-aligning them.
module lsu_multicycle #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_store,
  input  logic [1:0]        req_size,
  input  logic              req_signed,
  input  logic              req_update,
  input  logic              req_indexed,
  input  logic [REG_AW-1:0] req_ra,
  input  logic [REG_AW-1:0] req_rt,
  input  logic [XLEN-1:0]   ra_val,
  input  logic [XLEN-1:0]   rb_val,
  input  logic [XLEN-1:0]   rs_val,
  input  logic [15:0]       imm,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN/8-1:0] mem_be,
  output logic [XLEN-1:0]   mem_wdata,
  input  logic              mem_ack,
  input  logic [XLEN-1:0]   mem_rdata,
  output logic              wb_valid,
  output logic [REG_AW-1:0] wb_rd,
  output logic [XLEN-1:0]   wb_data,
  output logic              fault
);

  localparam int NB = XLEN / 8;
  localparam int OW = $clog2(NB);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB, S_UPD} state_t;

  state_t state, state_n;

  logic              st_q, sgn_q, upd_q;
  logic [1:0]        size_q;
  logic [REG_AW-1:0] ra_q, rt_q;
  logic [ADDR_W-1:0] ea_q;
  logic [OW-1:0]     off_q;
  logic [XLEN-1:0]   ld_q;

  logic [XLEN-1:0]   imm_x, base, ea_x;
  logic [ADDR_W-1:0] ea;
  logic [OW-1:0]     off_raw, off_al;
  logic              illegal;
  logic [NB-1:0]     be_n;
  logic [XLEN-1:0]   wdata_n;
  logic [XLEN-1:0]   ld_ext;
  logic [7:0]        ld_b;
  logic [15:0]       ld_h;
  int                sh_st, sh_ld;

  assign req_ready = (state == S_IDLE);

  always_comb begin
    imm_x   = XLEN'($signed(imm));
    base    = (req_ra == '0 && !req_update) ? '0 : ra_val;
    ea_x    = base + (req_indexed ? rb_val : imm_x);
    ea      = ADDR_W'(ea_x);
    off_raw = ea[OW-1:0];
    case (req_size)
      2'b01:   off_al = off_raw & ~OW'(1);
      2'b10:   off_al = '0;
      default: off_al = off_raw;
    endcase
    illegal = (req_size == 2'b11) || (req_update && req_ra == '0) ||
              (!req_store && req_update && req_ra == req_rt);
`ifdef LSU_ALIGN_CHECK_EN
    if ((req_size == 2'b01 && off_raw[0]) || (req_size == 2'b10 && off_raw != '0))
      illegal = 1'b1;
`endif
    // Big-endian lanes: offset 0 maps to the most significant byte enable.
    sh_st   = 0;
    be_n    = '1;
    wdata_n = rs_val;
    case (req_size)
      2'b00: begin
        sh_st   = NB - 1 - int'(off_al);
        be_n    = NB'(1) << sh_st;
        wdata_n = {NB{rs_val[7:0]}};
      end
      2'b01: begin
        sh_st   = NB - 2 - int'(off_al);
        be_n    = NB'(3) << sh_st;
        wdata_n = {(NB/2){rs_val[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    sh_ld  = 0;
    ld_b   = '0;
    ld_h   = '0;
    ld_ext = mem_rdata;
    case (size_q)
      2'b00: begin
        sh_ld  = 8 * (NB - 1 - int'(off_q));
        ld_b   = 8'(mem_rdata >> sh_ld);
        ld_ext = XLEN'(ld_b);
      end
      2'b01: begin
        sh_ld = 8 * (NB - 2 - int'(off_q));
        ld_h  = 16'(mem_rdata >> sh_ld);
        if (sgn_q) ld_ext = XLEN'($signed(ld_h));
        else       ld_ext = XLEN'(ld_h);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_n;
  end

  // An ack seen in ISSUE completes the access immediately, skipping WAIT.
  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (req_valid && !illegal) state_n = S_ISSUE;
      S_ISSUE, S_WAIT: begin
        if (mem_ack) begin
          if (!st_q)     state_n = S_WB;
          else if (upd_q) state_n = S_UPD;
          else            state_n = S_IDLE;
        end else begin
          state_n = S_WAIT;
        end
      end
      S_WB:    state_n = upd_q ? S_UPD : S_IDLE;
      S_UPD:   state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_be    <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      fault     <= 1'b0;
      st_q      <= 1'b0;
      sgn_q     <= 1'b0;
      upd_q     <= 1'b0;
      size_q    <= '0;
      ra_q      <= '0;
      rt_q      <= '0;
      ea_q      <= '0;
      off_q     <= '0;
      ld_q      <= '0;
    end else begin
      wb_valid <= 1'b0;
      fault    <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            if (illegal) begin
              fault <= 1'b1;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_store;
              mem_addr  <= ea & ~ADDR_W'(NB - 1);
              mem_be    <= be_n;
              mem_wdata <= wdata_n;
              st_q      <= req_store;
              sgn_q     <= req_signed;
              upd_q     <= req_update;
              size_q    <= req_size;
              ra_q      <= req_ra;
              rt_q      <= req_rt;
              ea_q      <= ea;
              off_q     <= off_al;
            end
          end
        end
        S_ISSUE, S_WAIT: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            ld_q    <= ld_ext;
          end
        end
        S_WB: begin
          wb_valid <= 1'b1;
          wb_rd    <= rt_q;
          wb_data  <= ld_q;
        end
        S_UPD: begin
          wb_valid <= 1'b1;
          wb_rd    <= ra_q;
          wb_data  <= XLEN'(ea_q);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_multicycle.sv
// Scoreboard bench for lsu_multicycle: expected writebacks are queued at issue and popped on wb_valid.
module tb_lsu_multicycle;
  localparam int XLEN = 32, ADDR_W = 32, REG_AW = 5;
`ifdef LSU_ALIGN_CHECK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic clk, rst;
  logic req_valid, req_ready, req_store, req_signed, req_update, req_indexed;
  logic [1:0] req_size;
  logic [REG_AW-1:0] req_ra, req_rt;
  logic [XLEN-1:0] ra_val, rb_val, rs_val;
  logic [15:0] imm;
  logic mem_req, mem_we, mem_ack;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0] mem_wdata, mem_rdata;
  logic wb_valid, fault;
  logic [REG_AW-1:0] wb_rd;
  logic [XLEN-1:0] wb_data;

  lsu_multicycle #(.XLEN(XLEN), .ADDR_W(ADDR_W), .REG_AW(REG_AW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_store(req_store),
    .req_size(req_size), .req_signed(req_signed), .req_update(req_update),
    .req_indexed(req_indexed), .req_ra(req_ra), .req_rt(req_rt),
    .ra_val(ra_val), .rb_val(rb_val), .rs_val(rs_val), .imm(imm),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data), .fault(fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } wb_t;

  wb_t sb[$];
  wb_t exp_wb;
  int  n_tests = 0;
  int  n_fail  = 0;
  int  last_wb_cyc = -1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst && wb_valid) begin
      last_wb_cyc = cyc;
      if (sb.size() == 0) begin
        check("wb_spurious", 1'b1, 1'b0);
      end else begin
        exp_wb = sb.pop_front();
        check("wb_rd", wb_rd, exp_wb.rd);
        check("wb_data", wb_data, exp_wb.data);
      end
    end
  end

  task automatic drive_req(input logic st, input logic [1:0] sz, input logic sg, input logic up,
                           input logic idx, input logic [4:0] ra, input logic [4:0] rt,
                           input logic [31:0] rav, input logic [31:0] rbv,
                           input logic [31:0] rsv, input logic [15:0] im);
    req_valid = 1'b1; req_store = st; req_size = sz; req_signed = sg; req_update = up;
    req_indexed = idx; req_ra = ra; req_rt = rt; ra_val = rav; rb_val = rbv;
    rs_val = rsv; imm = im;
  endtask

  task automatic run_op(input string nm, input logic st, input logic [1:0] sz, input logic sg,
                        input logic up, input logic idx, input logic [4:0] ra, input logic [4:0] rt,
                        input logic [31:0] rav, input logic [31:0] rbv, input logic [31:0] rsv,
                        input logic [15:0] im, input logic exp_flt, input logic [31:0] e_addr,
                        input logic [3:0] e_be, input logic [31:0] e_wd, input int waits,
                        input logic [31:0] rdata, input logic [31:0] e_ld, input logic [31:0] e_ea,
                        output int acc_c, output int done_c);
    bit seen, ok;
    seen = 1'b0; ok = 1'b0; done_c = -1;
    @(negedge clk);
    drive_req(st, sz, sg, up, idx, ra, rt, rav, rbv, rsv, im);
    acc_c = cyc;
    check({nm, ".ready"}, req_ready, 1'b1);
    @(posedge clk); #1 req_valid = 1'b0;
    if (exp_flt) begin
      @(negedge clk);
      check({nm, ".fault"}, fault, 1'b1);
      check({nm, ".no_req"}, mem_req, 1'b0);
      check({nm, ".ready_kept"}, req_ready, 1'b1);
      @(negedge clk);
      check({nm, ".fault_pulse"}, fault, 1'b0);
      check({nm, ".no_req2"}, mem_req, 1'b0);
      done_c = cyc;
      return;
    end
    if (!st) sb.push_back('{rd: rt, data: e_ld});
    if (up)  sb.push_back('{rd: ra, data: e_ea});
    @(negedge clk);
    check({nm, ".no_fault"}, fault, 1'b0);
    check({nm, ".req"}, mem_req, 1'b1);
    check({nm, ".busy"}, req_ready, 1'b0);
    check({nm, ".we"}, mem_we, st);
    check({nm, ".addr"}, mem_addr, e_addr);
    check({nm, ".be"}, mem_be, e_be);
    if (st) check({nm, ".wdata"}, mem_wdata, e_wd);
    for (int i = 0; i < waits; i++) begin
      @(negedge clk);
      check({nm, ".hold"}, {mem_req, mem_addr, mem_be}, {1'b1, e_addr, e_be});
    end
    mem_ack = 1'b1; mem_rdata = rdata;
    @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = $urandom;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) check({nm, ".req_drop"}, mem_req, 1'b0);
      if (req_ready && !seen) begin seen = 1'b1; done_c = cyc; end
      if (seen && sb.size() == 0) begin ok = 1'b1; break; end
    end
    check({nm, ".done"}, ok, 1'b1);
    if (!ok) sb.delete();
  endtask

  int a, d;

  initial begin
    rst = 1'b0; req_valid = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    drive_req(1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, '0, '0, '0, '0);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("rst.mem_req", mem_req, 1'b0);
    check("rst.mem_we", mem_we, 1'b0);
    check("rst.wb_valid", wb_valid, 1'b0);
    check("rst.fault", fault, 1'b0);
    check("rst.ready", req_ready, 1'b1);
    check("rst.addr_be", {mem_addr, mem_be}, '0);
    check("rst.wdata", mem_wdata, '0);
    check("rst.wb", {wb_rd, wb_data}, '0);
    rst = 1'b1;

    // EA = 2 + 1 = 3, word load, two wait cycles
    run_op("lwz", 0, 2'b10, 0, 0, 0, 5'd2, 5'd1, 32'd2, 0, 0, 16'd1, ALIGN_CHK,
           32'd0, 4'b1111, 0, 2, 32'd8, 32'd8, 0, a, d);
    // zero-wait word load: writeback appears three cycles after the accept cycle
    run_op("lwz0", 0, 2'b10, 0, 0, 0, 5'd2, 5'd3, 32'd8, 0, 0, 16'd0, 0,
           32'd8, 4'b1111, 0, 0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 0, a, d);
    check("lwz0.lat", last_wb_cyc, a + 3);
    run_op("lhax", 0, 2'b01, 1, 0, 1, 5'd3, 5'd5, 32'd2, 32'd4, 0, 16'd0, 0,
           32'd4, 4'b0011, 0, 1, 32'h1234_8001, 32'hFFFF_8001, 0, a, d);
    run_op("lhzx", 0, 2'b01, 0, 0, 1, 5'd3, 5'd5, 32'd2, 32'd4, 0, 16'd0, 0,
           32'd4, 4'b0011, 0, 1, 32'h1234_8001, 32'h0000_8001, 0, a, d);
    run_op("stbu", 1, 2'b00, 0, 1, 0, 5'd4, 5'd9, 32'd4, 0, 32'hA5, 16'd3, 0,
           32'd4, 4'b0001, 32'hA5A5_A5A5, 1, 0, 0, 32'd7, a, d);
    // zero-wait plain store releases two cycles after accept; RA=0 means base 0
    run_op("sth0", 1, 2'b01, 0, 0, 0, 5'd0, 5'd9, 32'h55, 0, 32'h1234_BEEF, 16'd2, 0,
           32'd0, 4'b0011, 32'hBEEF_BEEF, 0, 0, 0, 0, a, d);
    check("sth0.lat", d, a + 2);
    run_op("lbz", 0, 2'b00, 1, 0, 0, 5'd0, 5'd7, 32'h99, 0, 0, 16'd1, 0,
           32'd0, 4'b0100, 0, 0, 32'h11F2_3344, 32'h0000_00F2, 0, a, d);
    run_op("lwz_neg", 0, 2'b10, 0, 0, 0, 5'd6, 5'd8, 32'h100, 0, 0, 16'hFFFC, 0,
           32'hFC, 4'b1111, 0, 3, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, a, d);
    run_op("lwzu", 0, 2'b10, 0, 1, 0, 5'd6, 5'd10, 32'h100, 0, 0, 16'd8, 0,
           32'h108, 4'b1111, 0, 0, 32'h55, 32'h55, 32'h108, a, d);
    run_op("lwz5", 0, 2'b10, 0, 0, 0, 5'd2, 5'd11, 32'd5, 0, 0, 16'd0, ALIGN_CHK,
           32'd4, 4'b1111, 0, 1, 32'h77, 32'h77, 0, a, d);
    run_op("lhz7", 0, 2'b01, 0, 0, 0, 5'd2, 5'd12, 32'd7, 0, 0, 16'd0, ALIGN_CHK,
           32'd4, 4'b0011, 0, 0, 32'h0000_ABCD, 32'h0000_ABCD, 0, a, d);
    run_op("lwzu_ra0", 0, 2'b10, 0, 1, 0, 5'd0, 5'd3, 32'h40, 0, 0, 16'd4, 1,
           0, 0, 0, 0, 0, 0, 0, a, d);
    run_op("size11", 0, 2'b11, 0, 0, 0, 5'd2, 5'd3, 32'h40, 0, 0, 16'd4, 1,
           0, 0, 0, 0, 0, 0, 0, a, d);
    run_op("lwzu_rart", 0, 2'b10, 0, 1, 0, 5'd3, 5'd3, 32'h40, 0, 0, 16'd4, 1,
           0, 0, 0, 0, 0, 0, 0, a, d);

    // reset while WAIT holds a request; a late ack must not produce a writeback
    @(negedge clk);
    drive_req(0, 2'b10, 0, 0, 0, 5'd2, 5'd13, 32'h40, 0, 0, 16'd0);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    check("rstw.req", mem_req, 1'b1);
    @(negedge clk);
    check("rstw.hold", mem_req, 1'b1);
    #2 rst = 1'b0;
    #1 check("rstw.async_drop", mem_req, 1'b0);
    check("rstw.ready", req_ready, 1'b1);
    @(negedge clk);
    rst = 1'b1; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    @(posedge clk); #1 mem_ack = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("rstw.no_wb", {wb_valid, mem_req}, 2'b00);
    end
    run_op("post_rst", 0, 2'b10, 0, 0, 0, 5'd2, 5'd14, 32'h20, 0, 0, 16'd0, 0,
           32'h20, 4'b1111, 0, 1, 32'h3333_4444, 32'h3333_4444, 0, a, d);

    repeat (3) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/lsu_multicycle.md
Name: lsu_multicycle

Overview:
- Parametrised multi-cycle load/store unit for the uPower datapath.
- Replaces the single-cycle lwz/stw path with a handshaked unit supporting byte/half/word accesses, sign extension, D-form and X-form addressing, and update (RA writeback) forms.
- Sits between decode/register-read and a variable-latency data memory.
- Results return to the register file through a single write port, serialised.

Parameters:
XLEN, 32, data/register width in bits; multiple of 16
ADDR_W, 32, byte-address width driven to memory
REG_AW, 5, register index width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low
req_valid  in  1  decoded memory op present
req_ready  out  1  unit can accept op (high only in IDLE)
req_store  in  1  1 = store, 0 = load
req_size  in  2  00 byte, 01 half, 10 word; 11 illegal
req_signed  in  1  sign-extend load (lha, lhax)
req_update  in  1  write EA back to RA (lwzu, stwu, ...)
req_indexed  in  1  1 = EA uses rb_val (X-form), 0 = EA uses imm (D-form)
req_ra  in  REG_AW  RA field
req_rt  in  REG_AW  RT/RS field
ra_val  in  XLEN  GPR[RA]
rb_val  in  XLEN  GPR[RB]
rs_val  in  XLEN  store data
imm  in  16  D field, sign-extended internally
mem_req  out  1  memory request, held until mem_ack
mem_we  out  1  write strobe
mem_addr  out  ADDR_W  XLEN/8-aligned word address (low bits zero)
mem_be  out  XLEN/8  byte enables, bit XLEN/8-1 = byte offset 0
mem_wdata  out  XLEN  lane-replicated store data
mem_ack  in  1  memory completion; rdata valid same cycle
mem_rdata  in  XLEN  read data
wb_valid  out  1  one-cycle register write pulse
wb_rd  out  REG_AW  destination register
wb_data  out  XLEN  write data
fault  out  1  one-cycle pulse: illegal size or invalid update form

Behaviour:
- Reset (rst low, asynchronous): state IDLE; mem_req, mem_we, wb_valid and fault = 0; mem_addr, mem_be, mem_wdata, wb_rd and wb_data = 0. Asserting rst mid-access drops mem_req immediately; the op is discarded and a late mem_ack is ignored.
- EA calculation:
  - base = 0 if req_ra == 0 and req_update == 0; otherwise ra_val.
  - EA = base + (req_indexed ? rb_val : sext(imm)), computed modulo 2^XLEN and truncated or zero-extended to ADDR_W.
  - The op is latched on req_valid & req_ready.
- States:
  - IDLE: req_ready = 1. On accept, go to ISSUE. If the op is illegal (size 11, or update with RA = 0, or load-update with RA = RT), pulse fault and stay in IDLE.
  - ISSUE: assert mem_req, mem_we, mem_addr, mem_be and mem_wdata; go to WAIT. These outputs hold stable until ack.
  - WAIT: hold the request. On mem_ack, drop mem_req next cycle and capture the lane-selected rdata.
    - Load: go to WB.
    - Store with update: go to UPD.
    - Plain store: go to IDLE.
  - WB: wb_valid = 1, wb_rd = RT, wb_data = extended load value. Go to UPD if update, else IDLE.
  - UPD: wb_valid = 1, wb_rd = RA, wb_data = EA zero-extended to XLEN. Go to IDLE.
- Lane selection is big-endian: byte offset 0 is the most significant lane.
  - Byte: mem_be one-hot at the offset.
  - Half: offset bit 0 must be 0; two adjacent lanes enabled.
  - Word: all lanes enabled.
  - Store data is replicated across lanes.
  - Loads zero-extend, unless req_signed (half only) is set, which sign-extends.
- Latency:
  - Zero-wait memory (mem_ack in the first ISSUE cycle): load 3 cycles from accept to wb_valid; store releases to IDLE 2 cycles after accept.
  - mem_ack arriving in ISSUE is honoured the same as in WAIT.
- Throughput: one op in flight; req_ready = 0 outside IDLE.
- mem_ack while not in ISSUE or WAIT is ignored.

Optional Feature:
- Macro: LSU_ALIGN_CHECK_EN.
- Defined: a half access with an odd offset, or a word access with a nonzero low offset, pulses fault in IDLE. No memory request is issued, no writeback occurs, and the unit stays in IDLE.
- Undefined: misaligned low address bits are forced to the natural alignment (half clears bit 0, word clears all offset bits) and the access proceeds; fault covers only the illegal-size and invalid-update cases.

Test Plan:
- Reset and basic load: ra_val=2, imm=1, RT=1, word load, mem_rdata=8, ack after 2 wait cycles -> mem_addr=0, mem_be=4'b1111; wb_valid with rd=1, data=8; zero-wait ack gives wb 3 cycles after accept.
- lha sign extension: EA=6, mem_rdata=32'h1234_8001 -> mem_be=4'b0011, wb_data=32'hFFFF_8001; the same op as lhz gives 32'h0000_8001.
- stbu: RA=4, ra_val=4, imm=3, rs_val=32'hA5 -> mem_addr=4, mem_be=4'b0001, mem_wdata=32'hA5A5_A5A5, mem_we=1; then one wb pulse rd=4, data=7.
- Illegal ops: lwzu with RA=0, and a size=11 op -> fault pulses one cycle, no mem_req, req_ready stays 1.
- Reset mid-WAIT: drive rst low while mem_req=1 -> mem_req=0 asynchronously; a later mem_ack produces no wb_valid; the next op completes normally.
- LSU_ALIGN_CHECK_EN: word load at EA=5 -> defined: fault, no mem_req; undefined: mem_addr=4, mem_be=4'b1111, normal writeback.
